idx_prefix_seq: RTL and testbench

IDX_PREFIX_SEQ -- requirements
Module: idx_prefix_seq

---
 rtl/idx_prefix_seq_pkg.sv | 33 +++
 rtl/idx_prefix_seq_ea_adder.sv | 39 +++
 rtl/idx_prefix_seq.sv | 183 ++++++++++++++++++
 tb/tb_idx_prefix_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idx_prefix_seq_pkg.sv
// Shared definitions for the indexed-prefix sequencer: FSM state codes,
// prefix/opcode constants and the memory-form opcode decode.
package idx_prefix_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_PREFIX  = 3'd1;
    localparam state_t ST_DISP    = 3'd2;
    localparam state_t ST_CB_DISP = 3'd3;
    localparam state_t ST_CB_OP   = 3'd4;
    localparam state_t ST_EXEC    = 3'd5;

    localparam int MAX_IDX = 4;

    // Register k is selected by byte k of this table (LSB first); codes for
    // registers 2 and 3 are placeholders until those registers get real prefixes.
    localparam logic [MAX_IDX*8-1:0] PREFIX_CODES = {8'hEE, 8'hED, 8'hFD, 8'hDD};

    localparam logic [7:0] CB_CODE   = 8'hCB;
    localparam logic [7:0] HALT_CODE = 8'h76;

    function automatic logic [7:0] prefix_code(input int k);
        return PREFIX_CODES[k*8 +: 8];
    endfunction

    // Opcodes addressing (HL) in either operand field take a displacement byte;
    // 0x76 would match both fields but is HALT, not a memory access.
    function automatic logic is_mem_form(input logic [7:0] op);
        return ((op[2:0] == 3'b110) || (op[5:3] == 3'b110)) && (op != HALT_CODE);
    endfunction

endpackage

// File: rtl/idx_prefix_seq_ea_adder.sv
// Effective-address datapath: one-hot index register select, displacement
// sign extension and a modulo-2^ADDR_W add.
module idx_ea_adder
    import idx_prefix_seq_pkg::*;
#(
    parameter int NUM_IDX = 2,
    parameter int ADDR_W  = 16,
    parameter int DISP_W  = 8
) (
    input  logic [NUM_IDX*ADDR_W-1:0] idx_value,
    input  logic [NUM_IDX-1:0]        sel_idx,
    input  logic [DISP_W-1:0]         disp,
    output logic [ADDR_W-1:0]         ea
);

    logic [ADDR_W-1:0] idx_sel;
    logic [ADDR_W-1:0] disp_ext;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise the unassigned paths infer latches.
    always_comb begin
        idx_sel = '0;
        for (int k = 0; k < NUM_IDX; k++) begin
            if (sel_idx[k]) begin
                idx_sel = idx_sel | idx_value[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        disp_ext = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            disp_ext[i] = disp[(i < DISP_W) ? i : DISP_W - 1];
        end
    end

    assign ea = idx_sel + disp_ext;

endmodule

// File: rtl/idx_prefix_seq.sv
// Index-prefix byte sequencer: parses prefix / CB / displacement / opcode
// bytes and emits a registered effective address with a one-cycle strobe.
module idx_prefix_seq
    import idx_prefix_seq_pkg::*;
#(
    parameter int NUM_IDX = 2,
    parameter int ADDR_W  = 16,
    parameter int DISP_W  = 8
) (
    input  logic                      clk,
    input  logic                      not_reset,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [7:0]                op_byte,
    input  logic                      abort,
    input  logic [NUM_IDX*ADDR_W-1:0] idx_value,
    output logic [NUM_IDX-1:0]        sel_idx,
    output logic [NUM_IDX-1:0]        p2_set_disp,
    output logic [ADDR_W-1:0]         ea,
    output logic                      ea_valid,
    output logic [7:0]                op_out,
    output logic                      is_cb,
    output logic                      seq_busy
);

    state_t               state, state_nxt;
    logic [NUM_IDX-1:0]   sel_nxt;
    logic [NUM_IDX-1:0]   p2_nxt;
    logic                 is_cb_nxt;
    logic [7:0]           op_nxt;
    logic [DISP_W-1:0]    disp_q, disp_nxt;
    logic [DISP_W-1:0]    byte_disp;
    logic [DISP_W-1:0]    ea_disp;
    logic                 ea_load;
    logic [ADDR_W-1:0]    ea_sum;
    logic                 accept;
    logic [NUM_IDX-1:0]   prefix_sel;
    logic                 prefix_hit;

    assign op_ready = (state != ST_EXEC);
    assign seq_busy = (state != ST_IDLE);
    assign accept   = op_valid && op_ready;

    always_comb begin
        prefix_sel = '0;
        for (int k = 0; k < NUM_IDX; k++) begin
            if (op_byte == prefix_code(k)) begin
                prefix_sel[k] = 1'b1;
            end
        end
    end

    assign prefix_hit = |prefix_sel;

    // Displacement bytes are sign-extended or truncated to DISP_W.
    always_comb begin
        byte_disp = '0;
        for (int i = 0; i < DISP_W; i++) begin
            byte_disp[i] = op_byte[(i < 8) ? i : 7];
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_idx;
        is_cb_nxt = is_cb;
        op_nxt    = op_out;
        disp_nxt  = disp_q;
        p2_nxt    = '0;
        ea_load   = 1'b0;
        ea_disp   = disp_q;

        case (state)
            ST_IDLE: begin
                if (accept && prefix_hit) begin
                    state_nxt = ST_PREFIX;
                    sel_nxt   = prefix_sel;
                end
            end
            ST_PREFIX: begin
                if (accept) begin
                    if (prefix_hit) begin
                        sel_nxt = prefix_sel;
                    end else if (op_byte == CB_CODE) begin
                        state_nxt = ST_CB_DISP;
                        is_cb_nxt = 1'b1;
                    end else if (is_mem_form(op_byte)) begin
                        state_nxt = ST_DISP;
                        op_nxt    = op_byte;
                        p2_nxt    = sel_idx;
                    end else begin
                        state_nxt = ST_EXEC;
                        op_nxt    = op_byte;
                        ea_disp   = '0;
                        ea_load   = 1'b1;
                    end
                end
            end
            ST_DISP: begin
                if (accept) begin
                    state_nxt = ST_EXEC;
                    disp_nxt  = byte_disp;
                    ea_disp   = byte_disp;
                    ea_load   = 1'b1;
                end
            end
            ST_CB_DISP: begin
                if (accept) begin
                    state_nxt = ST_CB_OP;
                    disp_nxt  = byte_disp;
                    p2_nxt    = sel_idx;
                end
            end
            ST_CB_OP: begin
                if (accept) begin
                    state_nxt = ST_EXEC;
                    op_nxt    = op_byte;
                    ea_load   = 1'b1;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_IDLE;
                sel_nxt   = '0;
                is_cb_nxt = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
                sel_nxt   = '0;
                is_cb_nxt = 1'b0;
            end
        endcase

        // Abort wins over any byte taken this cycle, except that an address
        // already being presented in EXEC is allowed to complete.
        if (abort && (state != ST_EXEC)) begin
            state_nxt = ST_IDLE;
            sel_nxt   = '0;
            is_cb_nxt = 1'b0;
            op_nxt    = op_out;
            disp_nxt  = disp_q;
            p2_nxt    = '0;
            ea_load   = 1'b0;
        end
    end

    idx_ea_adder #(
        .NUM_IDX (NUM_IDX),
        .ADDR_W  (ADDR_W),
        .DISP_W  (DISP_W)
    ) u_ea_adder (
        .idx_value (idx_value),
        .sel_idx   (sel_idx),
        .disp      (ea_disp),
        .ea        (ea_sum)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state       <= ST_IDLE;
            sel_idx     <= '0;
            p2_set_disp <= '0;
            ea          <= '0;
            ea_valid    <= 1'b0;
            op_out      <= 8'h00;
            is_cb       <= 1'b0;
            disp_q      <= '0;
        end else begin
            state       <= state_nxt;
            sel_idx     <= sel_nxt;
            p2_set_disp <= p2_nxt;
            ea_valid    <= ea_load;
            op_out      <= op_nxt;
            is_cb       <= is_cb_nxt;
            disp_q      <= disp_nxt;
            if (ea_load) begin
                ea <= ea_sum;
            end
        end
    end

endmodule

// File: tb/tb_idx_prefix_seq.sv
// Self-checking bench for idx_prefix_seq: a sequence-level parser model
// predicts each completed access, checked whenever ea_valid is high.
module tb_idx_prefix_seq;

    localparam int NUM_IDX = 2;
    localparam int ADDR_W  = 16;
    localparam int DISP_W  = 8;

    typedef logic [7:0] bq_t[$];

    typedef struct packed {
        logic [15:0] ea;
        logic [7:0]  op;
        logic        cb;
        logic [1:0]  sel;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      not_reset;
    logic                      op_valid;
    logic                      op_ready;
    logic [7:0]                op_byte;
    logic                      abort;
    logic [NUM_IDX*ADDR_W-1:0] idx_value;
    logic [NUM_IDX-1:0]        sel_idx;
    logic [NUM_IDX-1:0]        p2_set_disp;
    logic [ADDR_W-1:0]         ea;
    logic                      ea_valid;
    logic [7:0]                op_out;
    logic                      is_cb;
    logic                      seq_busy;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        exp_q[$];
    logic [1:0]  exp_p2;
    int          p2_seen;
    int          ev_seen;
    logic [15:0] last_ea;
    logic [7:0]  last_op;
    logic        last_cb;
    logic [1:0]  last_sel;

    idx_prefix_seq #(
        .NUM_IDX (NUM_IDX),
        .ADDR_W  (ADDR_W),
        .DISP_W  (DISP_W)
    ) dut (
        .clk         (clk),
        .not_reset   (not_reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_byte     (op_byte),
        .abort       (abort),
        .idx_value   (idx_value),
        .sel_idx     (sel_idx),
        .p2_set_disp (p2_set_disp),
        .ea          (ea),
        .ea_valid    (ea_valid),
        .op_out      (op_out),
        .is_cb       (is_cb),
        .seq_busy    (seq_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Parses one complete byte sequence: leading prefixes (last wins), then
    // either CB,disp,op or op[,disp] when the opcode addresses memory.
    function automatic void model(input bq_t b, input logic [31:0] idx,
                                  output exp_t e, output logic p2);
        int i = 0;
        int k = 0;
        logic [7:0] op;
        logic [7:0] d = 8'h00;
        e = '0;
        while (i < b.size() && (b[i] == 8'hDD || b[i] == 8'hFD)) begin
            k = (b[i] == 8'hFD) ? 1 : 0;
            e.sel = (k == 1) ? 2'b10 : 2'b01;
            i++;
        end
        if (b[i] == 8'hCB) begin
            e.cb = 1'b1;
            d    = b[i+1];
            op   = b[i+2];
            p2   = 1'b1;
        end else begin
            op = b[i];
            p2 = (((op & 8'h07) == 8'h06) || ((op & 8'h38) == 8'h30)) && (op != 8'h76);
            if (p2) d = b[i+1];
        end
        e.op = op;
        e.ea = idx[k*16 +: 16] + {{8{d[7]}}, d};
    endfunction

    always @(negedge clk) begin
        if (not_reset) begin
            check("ready_only_outside_exec", op_ready, !ea_valid);
            if (ea_valid) begin
                ev_seen++;
                last_ea  = ea;
                last_op  = op_out;
                last_cb  = is_cb;
                last_sel = sel_idx;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ea_valid: got ea=0x%0h op=0x%0h, expected no strobe", ea, op_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ea", ea, e.ea);
                    check("op_out", op_out, e.op);
                    check("is_cb", is_cb, e.cb);
                    check("sel_idx", sel_idx, e.sel);
                    check("busy_in_exec", seq_busy, 1);
                end
            end
            if (p2_set_disp != '0) begin
                p2_seen++;
                check("p2_set_disp_bits", p2_set_disp, exp_p2);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic ab);
        int guard = 0;
        op_byte  = b;
        op_valid = 1'b1;
        abort    = ab;
        while (!op_ready && guard < 16) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!op_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got op_ready=0, expected 1 within 16 cycles");
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic run_seq(input string name, input bq_t b, input logic [31:0] idx);
        exp_t e;
        logic p2;
        int   guard = 0;
        model(b, idx, e, p2);
        idx_value = idx;
        exp_q.push_back(e);
        exp_p2  = e.sel;
        p2_seen = 0;
        ev_seen = 0;
        foreach (b[i]) send_byte(b[i], 1'b0);
        while (exp_q.size() != 0 && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        check({name, "_completed"}, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        check({name, "_one_strobe"}, ev_seen, 1);
        check({name, "_p2_count"}, p2_seen, p2 ? 1 : 0);
        check({name, "_idle_after"}, seq_busy, 0);
        check({name, "_sel_cleared"}, sel_idx, 0);
    endtask

    initial begin
        bq_t seq;

        not_reset = 1'b0;
        op_valid  = 1'b0;
        op_byte   = 8'h00;
        abort     = 1'b0;
        idx_value = '0;
        exp_p2    = '0;
        p2_seen   = 0;
        ev_seen   = 0;

        @(negedge clk);
        check("rst_sel_idx", sel_idx, 0);
        check("rst_p2", p2_set_disp, 0);
        check("rst_ea", ea, 0);
        check("rst_ea_valid", ea_valid, 0);
        check("rst_op_out", op_out, 0);
        check("rst_is_cb", is_cb, 0);
        check("rst_busy", seq_busy, 0);
        @(posedge clk); #1;
        not_reset = 1'b1;
        @(negedge clk);
        check("rst_op_ready", op_ready, 1);
        @(posedge clk); #1;

        // IX-indexed load with positive displacement
        seq = '{8'hDD, 8'h7E, 8'h05};
        run_seq("ix_ld", seq, {16'h2345, 16'h1000});
        check("lit_ix_ld_ea", last_ea, 16'h1005);
        check("lit_ix_ld_op", last_op, 8'h7E);
        check("lit_ix_ld_sel", last_sel, 2'b01);

        // CB-prefixed IY bit op with negative displacement wrapping below zero
        seq = '{8'hFD, 8'hCB, 8'hFE, 8'h46};
        run_seq("iy_cb", seq, {16'h0001, 16'h1000});
        check("lit_iy_cb_ea", last_ea, 16'hFFFF);
        check("lit_iy_cb_cb", last_cb, 1);
        check("lit_iy_cb_op", last_op, 8'h46);

        // Repeated prefixes, last wins; register-only opcode skips DISP
        seq = '{8'hDD, 8'hFD, 8'hFD, 8'hE9};
        run_seq("jp_iy", seq, {16'h2345, 16'h1000});
        check("lit_jp_iy_sel", last_sel, 2'b10);
        check("lit_jp_iy_ea", last_ea, 16'h2345);
        check("lit_jp_iy_p2", p2_seen, 0);

        // Upward wrap-around
        seq = '{8'hDD, 8'h7E, 8'h20};
        run_seq("ix_wrap", seq, {16'h0000, 16'hFFF0});
        check("lit_ix_wrap_ea", last_ea, 16'h0010);

        // HALT is not a memory form even though both fields read 110
        seq = '{8'hDD, 8'h76};
        run_seq("halt", seq, {16'h0000, 16'h4000});
        check("lit_halt_ea", last_ea, 16'h4000);

        seq = '{8'hDD, 8'h86, 8'h80};
        run_seq("ix_add_neg", seq, {16'h0000, 16'h0100});
        seq = '{8'hFD, 8'h34, 8'h7F};
        run_seq("iy_inc_pos", seq, {16'h1000, 16'h0000});
        seq = '{8'hDD, 8'hCB, 8'h03, 8'hC6};
        run_seq("ix_cb_set", seq, {16'h0000, 16'h8000});

        // Non-prefix byte in IDLE is ignored
        send_byte(8'h7E, 1'b0);
        @(negedge clk);
        check("idle_junk_busy", seq_busy, 0);
        @(posedge clk); #1;

        // Abort on the displacement byte
        idx_value = {16'h0000, 16'h1000};
        exp_p2  = 2'b01;
        p2_seen = 0;
        ev_seen = 0;
        send_byte(8'hDD, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h05, 1'b1);
        @(negedge clk);
        check("abort_busy", seq_busy, 0);
        check("abort_sel", sel_idx, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_strobe", ev_seen, 0);
        check("abort_p2_count", p2_seen, 1);

        // Abort during EXEC still completes the strobe; byte offered then is not taken
        begin
            exp_t e;
            logic p2;
            seq = '{8'hDD, 8'hE9};
            model(seq, {16'h0000, 16'h0ABC}, e, p2);
            idx_value = {16'h0000, 16'h0ABC};
            exp_q.push_back(e);
            ev_seen = 0;
            send_byte(8'hDD, 1'b0);
            send_byte(8'hE9, 1'b0);
            abort    = 1'b1;
            op_valid = 1'b1;
            op_byte  = 8'hDD;
            @(posedge clk); #1;
            abort    = 1'b0;
            op_valid = 1'b0;
            check("exec_abort_strobe", ev_seen, 1);
            check("exec_abort_idle", seq_busy, 0);
            check("exec_abort_q", exp_q.size(), 0);
            exp_q.delete();
        end

        // Reset in the middle of a sequence discards everything
        idx_value = {16'h1234, 16'h0000};
        exp_p2  = 2'b10;
        ev_seen = 0;
        send_byte(8'hFD, 1'b0);
        send_byte(8'h36, 1'b0);
        not_reset = 1'b0;
        @(negedge clk);
        check("mid_rst_sel", sel_idx, 0);
        check("mid_rst_p2", p2_set_disp, 0);
        check("mid_rst_ea", ea, 0);
        check("mid_rst_ea_valid", ea_valid, 0);
        check("mid_rst_op_out", op_out, 0);
        check("mid_rst_is_cb", is_cb, 0);
        check("mid_rst_busy", seq_busy, 0);
        @(posedge clk); #1;
        not_reset = 1'b1;
        send_byte(8'h21, 1'b0);
        @(negedge clk);
        check("post_rst_busy", seq_busy, 0);
        check("post_rst_ready", op_ready, 1);
        check("post_rst_op_out", op_out, 0);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_no_strobe", ev_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
